// File: rtl/jtag_shift_engine_if.sv
// Command/response bundle between a host and the JTAG shift engine.
// Handshake: a transfer happens on the rising clk edge where valid and ready
// are both high. While valid is high and ready is low, the sender holds valid
// and its payload stable; ready may change freely and never waits on valid.
interface jtag_shift_engine_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = $clog2(DATA_W + 1)
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: turns one command (reset, TMS sequence, scan, idle
// clocks) into TCK/TMS/TDI waveforms and returns captured TDO for scans.
module jtag_shift_engine #(
  parameter int DATA_W = 32,
  parameter int DIV    = 50,
  parameter int LEN_W  = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  jtag_shift_engine_if.slave bus,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               busy,
  output logic [1:0]         state_dbg
);
  localparam int CNT_W = $clog2(DIV + 1) + 1;

  localparam logic [2:0] OP_RESET = 3'd0;
  localparam logic [2:0] OP_TMS   = 3'd1;
  localparam logic [2:0] OP_SCAN  = 3'd2;
  localparam logic [2:0] OP_FLIP  = 3'd3;
  localparam logic [2:0] OP_IDLE  = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_RESP} state_t;

  state_t            state, state_next;
  logic [2:0]        op_q;
  logic              err_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_idx;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cap_q;
  logic [CNT_W-1:0]  div_cnt;

  logic              accept;
  logic              phase_end;
  logic              last_bit;
  logic              resp_op;
  logic              acc_err;
  logic [LEN_W-1:0]  acc_len;

  // TMS level for bit idx of a command
  function automatic logic bit_tms(input logic [2:0] op, input logic [LEN_W-1:0] idx,
                                   input logic [LEN_W-1:0] len, input logic [DATA_W-1:0] data);
    case (op)
      OP_RESET: bit_tms = (idx != LEN_W'(5));
      OP_TMS:   bit_tms = data[idx];
      OP_FLIP:  bit_tms = (idx == len - LEN_W'(1));
      default:  bit_tms = 1'b0;
    endcase
  endfunction

  // TDI level for bit idx of a command
  function automatic logic bit_tdi(input logic [2:0] op, input logic [LEN_W-1:0] idx,
                                   input logic [DATA_W-1:0] data);
    bit_tdi = (op == OP_SCAN || op == OP_FLIP) ? data[idx] : 1'b0;
  endfunction

  // Effective length of the offered command: RESET is always 6 clocks,
  // illegal ops shift nothing, everything else is clamped to DATA_W.
  always_comb begin
    acc_err = (bus.cmd_op > OP_IDLE);
    if (acc_err)
      acc_len = '0;
    else if (bus.cmd_op == OP_RESET)
      acc_len = LEN_W'(6);
    else if (bus.cmd_len > LEN_W'(DATA_W))
      acc_len = LEN_W'(DATA_W);
    else
      acc_len = bus.cmd_len;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    phase_end  = (div_cnt == '0);
    last_bit   = (bit_idx == len_q - LEN_W'(1));
    resp_op    = err_q || (op_q == OP_SCAN) || (op_q == OP_FLIP);
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (len_q == '0)
          state_next = resp_op ? S_RESP : S_IDLE;
        else if (phase_end)
          state_next = S_HIGH;
      end
      S_HIGH: begin
        if (phase_end)
          state_next = last_bit ? (resp_op ? S_RESP : S_IDLE) : S_LOW;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command latch, phase counter, pin drive and TDO capture. The accept
  // cycle is spent in LOW as a decode cycle, so the first LOW phase is one
  // cycle longer; every later phase is exactly DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      err_q   <= 1'b0;
      len_q   <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      div_cnt <= '0;
      tck     <= 1'b0;
      tms     <= 1'b0;
      tdi     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= bus.cmd_op;
            err_q   <= acc_err;
            len_q   <= acc_len;
            data_q  <= bus.cmd_data;
            bit_idx <= '0;
            cap_q   <= '0;
            div_cnt <= CNT_W'(DIV);
            tms     <= (acc_len != '0) && bit_tms(bus.cmd_op, LEN_W'(0), acc_len, bus.cmd_data);
            tdi     <= (acc_len != '0) && bit_tdi(bus.cmd_op, LEN_W'(0), bus.cmd_data);
          end
        end
        S_LOW: begin
          if (len_q != '0) begin
            if (phase_end) begin
              tck            <= 1'b1;
              cap_q[bit_idx] <= tdo;
              div_cnt        <= CNT_W'(DIV - 1);
            end else begin
              div_cnt <= div_cnt - CNT_W'(1);
            end
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            tck     <= 1'b0;
            div_cnt <= CNT_W'(DIV - 1);
            if (last_bit) begin
              tms <= 1'b0;
              tdi <= 1'b0;
            end else begin
              bit_idx <= bit_idx + LEN_W'(1);
              tms     <= bit_tms(op_q, bit_idx + LEN_W'(1), len_q, data_q);
              tdi     <= bit_tdi(op_q, bit_idx + LEN_W'(1), data_q);
            end
          end else begin
            div_cnt <= div_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            err_q <= 1'b0;
            cap_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready = (state == S_IDLE) && !rst;
  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_data  = cap_q;
  assign bus.rsp_err   = err_q;
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;
endmodule

// File: doc/jtag_shift_engine.md
JTAG_SHIFT_ENGINE -- requirements
Module: jtag_shift_engine

Interface
REQ-001 Parameter DATA_W, default 32: maximum bits shifted per command; legal 8..256.
REQ-002 Parameter DIV, default 50: TCK half-period in clk cycles; legal >=1.
REQ-003 Parameter LEN_W, default $clog2(DATA_W+1): width of cmd_len.
REQ-004 clk  in  1  single block clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  engine accepts command this cycle.
REQ-008 cmd_op  in  3  0 RESET, 1 TMS_SEQ, 2 SCAN, 3 SCAN_FLIP_TMS, 4 IDLE_CLK, 5-7 illegal.
REQ-009 cmd_len  in  LEN_W  bit count for ops 1-4.
REQ-010 cmd_data  in  DATA_W  TMS bits (op 1) or TDI bits (ops 2/3), LSB shifted first.
REQ-011 rsp_valid  out  1  scan/error response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_data  out  DATA_W  captured TDO bits, bit i = TDO of shifted bit i.
REQ-014 rsp_err  out  1  response belongs to an illegal op.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 tck, tms, tdi  out  1 each  JTAG drive, registered; tdo  in  1  JTAG return.

Function
REQ-017 States: IDLE, LOW, HIGH, RESP; cmd_ready SHALL equal (state==IDLE).
REQ-018 Accept on clk edge with cmd_valid&&cmd_ready; op, clamped length and data latched; next cycle enters LOW (or RESP/IDLE per REQ-026..028).
REQ-019 cmd_len > DATA_W SHALL be clamped to DATA_W.
REQ-020 LOW: tck=0 for exactly DIV cycles; tms/tdi for current bit updated on entry to LOW.
REQ-021 HIGH: tck=1 for exactly DIV cycles; tdo sampled on the clk edge that enters HIGH (same edge tck rises) into rsp_data[bit].
REQ-022 One bit = 2*DIV clk cycles; N bits = N full TCK periods, no gap between bits.
REQ-023 RESET: 5 TCK with tms=1, then 1 TCK with tms=0; tdi=0; cmd_len/cmd_data ignored; no response.
REQ-024 TMS_SEQ: tms=cmd_data[i] for bit i, tdi=0; no response. IDLE_CLK: cmd_len TCK with tms=0, tdi=0; no response.
REQ-025 SCAN: tdi=cmd_data[i], tms=0 all bits. SCAN_FLIP_TMS: same, tms=1 on last bit only.
REQ-026 After final HIGH phase: tck=0, tms=0, tdi=0; scan ops enter RESP, others IDLE.
REQ-027 cmd_len=0 on ops 1-4: no TCK edges; scan ops go directly to RESP with rsp_data=0, others return to IDLE the cycle after accept.
REQ-028 Illegal op: no TCK edges; RESP with rsp_err=1, rsp_data=0.
REQ-029 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_valid&&rsp_ready, then IDLE next cycle; no new command accepted while in RESP.
REQ-030 rsp_data bits >= shifted length SHALL be 0; rsp_err=0 for legal ops.
REQ-031 tms/tdi SHALL change only while tck=0.

Reset
REQ-032 rst asserted at any time (including mid-shift or in RESP): state=IDLE, tck=0, tms=0, tdi=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, cmd_ready=0 while rst high; in-flight command discarded, no response.
REQ-033 First command accepted no earlier than the first clk edge after rst deasserts.

Verification
REQ-034 DIV=2, op RESET -> 6 TCK periods of 4 clk each; tms=1 for first 5 rising edges, 0 on sixth; busy high 24+1 cycles.
REQ-035 DIV=2, SCAN len=8 data=0xA5, tdo model = TAP bypass of 1 -> tdi sequence 1,0,1,0,0,1,0,1; rsp_data=0x4A (delayed by one bit, bypass reset 0), rsp_err=0, tms=0 throughout.
REQ-036 SCAN_FLIP_TMS len=5 data=0x1F, tdo tied 1 -> tms=1 only during 5th bit; rsp_data=0x1F, upper bits 0.
REQ-037 SCAN len=40 with DATA_W=32 -> exactly 32 TCK; cmd_len=0 -> no TCK, rsp_valid next-next cycle, rsp_data=0; op=6 -> rsp_err=1, no TCK.
REQ-038 rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0; release -> IDLE one cycle later.
REQ-039 rst pulsed during bit 3 of a 16-bit scan -> tck/tms/tdi=0 immediately, no rsp_valid; subsequent SCAN completes correctly.
